song_sequencer: RTL and testbench

- Initiator side of the note_player load interface.
- Walks a selected song stored in the song ROM (one entry = note + duration) and presents each entry to note_player as a one-cycle load pulse.
- Waits for note_player's done_with_note, then advances; flags completion at an end marker or after the last slot.
- Sits between the top-level control (play/new_song buttons) and note_player.

---
 rtl/song_sequencer.sv | 59 +++++
 tb/tb_song_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: walks a song in ROM and hands each note/duration to note_player
module song_sequencer #(
  parameter int SONG_BITS     = 2,
  parameter int NOTE_IDX_BITS = 5
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               play,
  input  logic                               new_song,
  input  logic [SONG_BITS-1:0]               song,
  output logic [SONG_BITS+NOTE_IDX_BITS-1:0] rom_addr,
  input  logic [11:0]                        rom_data,
  output logic [5:0]                         note_to_load,
  output logic [5:0]                         duration_to_load,
  output logic                               load_new_note,
  input  logic                               done_with_note,
  output logic                               song_done,
  output logic [NOTE_IDX_BITS-1:0]           note_index
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, LOAD, WAIT_DONE, DONE} state_t;
  state_t state, state_n;
  logic [NOTE_IDX_BITS-1:0] idx;
  logic [SONG_BITS-1:0] song_q;
  logic last;
  assign last       = &idx;
  assign rom_addr   = {song_q, idx};
  assign note_index = idx;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // next state and decoded outputs; a duration of zero in the ROM marks end of song
  always_comb begin
    state_n       = state;
    load_new_note = state == LOAD;
    song_done     = state == DONE;
    case (state)
      IDLE:      state_n = play ? FETCH : IDLE;
      FETCH:     state_n = CAPTURE;
      CAPTURE:   state_n = rom_data[5:0] == 6'd0 ? DONE : play ? LOAD : CAPTURE;
      LOAD:      state_n = WAIT_DONE;
      WAIT_DONE: state_n = !done_with_note ? WAIT_DONE : last ? DONE : FETCH;
      DONE:      state_n = DONE;
      default:   state_n = IDLE;
    endcase
    if (new_song) state_n = IDLE;
  end
  // slot index and latched song; the last slot finishes the song instead of wrapping
  always_ff @(posedge clk)
    if (reset || new_song) begin
      idx    <= '0;
      song_q <= song;
    end else if (state == WAIT_DONE && done_with_note && !last) begin
      idx <= idx + 1'b1;
    end
  // note/duration latch, only written while capturing so it holds through LOAD and WAIT_DONE
  always_ff @(posedge clk)
    if (reset) {note_to_load, duration_to_load} <= '0;
    else if (state == CAPTURE) {note_to_load, duration_to_load} <= rom_data;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: table-driven songs plus scoreboard of expected loads
module tb_song_sequencer;
  logic clk = 0, reset = 1, play = 0, new_song = 0, done_with_note = 0;
  logic [1:0] song = 0;
  logic [6:0] rom_addr;
  logic [11:0] rom_data;
  logic [5:0] note_to_load, duration_to_load;
  logic load_new_note, song_done;
  logic [4:0] note_index;
  logic [11:0] rom [128];

  typedef struct {logic [6:0] addr; logic [5:0] note; logic [5:0] dur;} exp_t;
  typedef struct {logic [1:0] song; int loads; int idx;} vec_t;
  exp_t sb[$];
  vec_t vecs[4];
  int checks = 0, failures = 0, load_count = 0;

  song_sequencer dut (
    .clk(clk), .reset(reset), .play(play), .new_song(new_song), .song(song),
    .rom_addr(rom_addr), .rom_data(rom_data), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .load_new_note(load_new_note),
    .done_with_note(done_with_note), .song_done(song_done), .note_index(note_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (load_new_note) begin
      load_count++;
      if (sb.size() == 0) check("unexpected_load", int'(load_new_note), 0);
      else begin
        e = sb.pop_front();
        check("load_addr", rom_addr, e.addr);
        check("load_note", note_to_load, e.note);
        check("load_dur", duration_to_load, e.dur);
      end
    end
  endtask

  task automatic do_reset(input logic [1:0] s);
    reset = 1; song = s; play = 0; done_with_note = 0; new_song = 0;
    sb.delete();
    cycle();
    reset = 0;
  endtask

  task automatic build_expected(input logic [1:0] s);
    exp_t x;
    logic [11:0] e;
    for (int i = 0; i < 32; i++) begin
      e = rom[int'(s) * 32 + i];
      if (e[5:0] == 6'd0) break;
      x.addr = 7'(int'(s) * 32 + i);
      x.note = e[11:6];
      x.dur  = e[5:0];
      sb.push_back(x);
    end
  endtask

  task automatic run_song(input vec_t v);
    int l0, cyc, since;
    do_reset(v.song);
    build_expected(v.song);
    l0 = load_count; cyc = 0; since = 0;
    play = 1;
    while (!song_done && cyc < 600) begin
      cycle(); cyc++; since++;
      if (load_new_note) begin
        check("load_latency", since, 3);
        cycle(); cyc++;
        done_with_note = 1;
        cycle(); cyc++;
        done_with_note = 0;
        since = 1;
      end
    end
    check("song_done_reached", int'(song_done), 1);
    check("load_total", load_count - l0, v.loads);
    check("final_idx", note_index, v.idx);
    check("sb_drained", sb.size(), 0);
    repeat (4) cycle();
    check("done_holds", int'(song_done), 1);
    check("no_extra_load", load_count - l0, v.loads);
  endtask

  initial begin
    int l0;
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0] = {6'd20, 6'd4}; rom[1] = {6'd24, 6'd2};
    rom[32] = {6'd5, 6'd3}; rom[33] = {6'd7, 6'd1}; rom[34] = {6'd9, 6'd2};
    for (int i = 0; i < 32; i++) rom[96 + i] = {6'(i + 1), 6'd1};
    vecs[0] = '{2'd0, 2, 2};
    vecs[1] = '{2'd1, 3, 3};
    vecs[2] = '{2'd2, 0, 0};
    vecs[3] = '{2'd3, 32, 31};

    do_reset(2'd2);
    check("rst_note", note_to_load, 0);
    check("rst_dur", duration_to_load, 0);
    check("rst_load", int'(load_new_note), 0);
    check("rst_song_done", int'(song_done), 0);
    check("rst_idx", note_index, 0);
    check("rst_addr", rom_addr, 7'h40);

    for (int i = 0; i < 4; i++) run_song(vecs[i]);

    // pause while holding in CAPTURE
    do_reset(2'd0);
    sb.push_back('{7'h00, 6'd20, 6'd4});
    l0 = load_count;
    play = 1;
    cycle();
    play = 0;
    cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("pause_no_load", int'(load_new_note), 0);
      check("pause_addr", rom_addr, 0);
      check("pause_note", note_to_load, 20);
      check("pause_dur", duration_to_load, 4);
    end
    play = 1;
    cycle();
    check("pause_resume_load", int'(load_new_note), 1);
    check("pause_load_count", load_count - l0, 1);

    // new_song and done together in WAIT_DONE
    do_reset(2'd0);
    sb.push_back('{7'h00, 6'd20, 6'd4});
    play = 1;
    repeat (3) cycle();
    cycle();
    new_song = 1; song = 2'd1; done_with_note = 1;
    cycle();
    new_song = 0; done_with_note = 0;
    check("abort_idx", note_index, 0);
    check("abort_addr", rom_addr, 7'h20);
    check("abort_load", int'(load_new_note), 0);
    check("abort_done", int'(song_done), 0);
    sb.push_back('{7'h20, 6'd5, 6'd3});
    l0 = load_count;
    cycle();
    check("abort_fetch_addr", rom_addr, 7'h20);
    cycle();
    check("abort_no_early_load", load_count - l0, 0);
    cycle();
    check("abort_reload", int'(load_new_note), 1);

    // done pulses outside WAIT_DONE are ignored
    do_reset(2'd0);
    build_expected(2'd0);
    l0 = load_count;
    play = 1; done_with_note = 1;
    repeat (3) cycle();
    check("spur_first_load", int'(load_new_note), 1);
    cycle();
    done_with_note = 0;
    check("spur_idx", note_index, 0);
    check("spur_single_load", load_count - l0, 1);
    done_with_note = 1;
    cycle();
    done_with_note = 0;
    repeat (2) cycle();
    check("spur_second_load", int'(load_new_note), 1);
    check("spur_idx_adv", note_index, 1);
    check("spur_load_total", load_count - l0, 2);

    // reset in the middle of a note
    do_reset(2'd0);
    sb.push_back('{7'h00, 6'd20, 6'd4});
    play = 1;
    repeat (3) cycle();
    cycle();
    reset = 1; song = 2'd3;
    cycle();
    reset = 0; play = 0;
    check("mrst_note", note_to_load, 0);
    check("mrst_dur", duration_to_load, 0);
    check("mrst_load", int'(load_new_note), 0);
    check("mrst_song_done", int'(song_done), 0);
    check("mrst_idx", note_index, 0);
    check("mrst_addr", rom_addr, 7'h60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
